// File: rtl/pe_pkg.sv
// pe_pkg - shared definitions for the multi-channel processing element.
//   * default widths/sizes used as parameter defaults by pe_mc_if and pe_mc
//   * FSM state encoding
//   * cfg_legal(): window configuration legality check
package pe_pkg;

    localparam int DATA_WIDTH_DEF       = 16;
    localparam int ACC_WIDTH_DEF        = 32;
    localparam int MAX_FILTER_WIDTH_DEF = 11;
    localparam int MAX_CH_DEF           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pe_state_e;

    // A window is legal when 1 <= fw <= mfw, 1 <= stride <= fw, 1 <= nch <= max_ch.
    function automatic logic cfg_legal(input int unsigned fw,
                                       input int unsigned stride,
                                       input int unsigned nch,
                                       input int unsigned mfw,
                                       input int unsigned max_ch);
        return (fw >= 32'd1) && (fw <= mfw) &&
               (stride >= 32'd1) && (stride <= fw) &&
               (nch >= 32'd1) && (nch <= max_ch);
    endfunction

endpackage

// File: rtl/pe_mc_if.sv
// pe_mc_if - data/handshake bundle of the processing element.
//   ifmap stream  : i_ifmap_data, i_ifmap_valid
//   weight writes : i_weight_data, i_weight_valid, i_wr_w_{ch,row,col}_ptr
//   result        : o_peout_data, o_peout_valid, o_peout_sat, i_peout_ready
// slave = the PE, master = whoever feeds it and drains results.
interface pe_mc_if
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH        = ACC_WIDTH_DEF,
    parameter int MAX_FILTER_WIDTH = MAX_FILTER_WIDTH_DEF,
    parameter int MAX_CH           = MAX_CH_DEF,
    localparam int LOG_MFW         = $clog2(MAX_FILTER_WIDTH),
    localparam int LOG_CH          = $clog2(MAX_CH)
);

    logic signed [DATA_WIDTH-1:0] i_ifmap_data;
    logic                         i_ifmap_valid;

    logic signed [DATA_WIDTH-1:0] i_weight_data;
    logic                         i_weight_valid;
    logic [LOG_CH:0]              i_wr_w_ch_ptr;
    logic [LOG_MFW:0]             i_wr_w_row_ptr;
    logic [LOG_MFW:0]             i_wr_w_col_ptr;

    logic signed [ACC_WIDTH-1:0]  o_peout_data;
    logic                         o_peout_valid;
    logic                         o_peout_sat;
    logic                         i_peout_ready;

    modport slave (
        input  i_ifmap_data, i_ifmap_valid,
        input  i_weight_data, i_weight_valid,
        input  i_wr_w_ch_ptr, i_wr_w_row_ptr, i_wr_w_col_ptr,
        input  i_peout_ready,
        output o_peout_data, o_peout_valid, o_peout_sat
    );

    modport master (
        output i_ifmap_data, i_ifmap_valid,
        output i_weight_data, i_weight_valid,
        output i_wr_w_ch_ptr, i_wr_w_row_ptr, i_wr_w_col_ptr,
        output i_peout_ready,
        input  o_peout_data, o_peout_valid, o_peout_sat
    );

endinterface

// File: rtl/pe_mac.sv
// pe_mac - combinational multiply-accumulate step.
//   acc      in  ACC_WIDTH   current accumulator
//   weight   in  DATA_WIDTH  signed weight
//   ifmap    in  DATA_WIDTH  signed ifmap sample
//   acc_next out ACC_WIDTH   acc + weight*ifmap (clamped when SATURATE)
//   sat      out 1           this step overflowed and was clamped
module pe_mac
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter bit SATURATE   = 1'b1
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic signed [DATA_WIDTH-1:0] weight,
    input  logic signed [DATA_WIDTH-1:0] ifmap,
    output logic signed [ACC_WIDTH-1:0]  acc_next,
    output logic                         sat
);

    localparam int PW  = 2 * DATA_WIDTH;
    localparam int EXT = ACC_WIDTH + 1 - PW;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [PW-1:0]        w_ext, x_ext, prod;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf;

    // The low PW bits of a product of sign-extended operands equal the
    // signed product, so an unsigned multiply at PW bits is sufficient.
    assign w_ext = {{DATA_WIDTH{weight[DATA_WIDTH-1]}}, weight};
    assign x_ext = {{DATA_WIDTH{ifmap[DATA_WIDTH-1]}}, ifmap};
    assign prod  = w_ext * x_ext;

    // One guard bit: overflow iff the two top bits of the widened sum differ.
    assign sum = {acc[ACC_WIDTH-1], acc} + {{EXT{prod[PW-1]}}, prod};
    assign ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

    always_comb begin
        acc_next = sum[ACC_WIDTH-1:0];
        sat      = 1'b0;
        if (SATURATE && ovf) begin
            acc_next = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            sat      = 1'b1;
        end
    end

endmodule

// File: rtl/pe_mc.sv
// pe_mc - multi-channel convolution processing element.
// Accumulates weight[ch][row][col] * ifmap over an fw x fw window for
// num_ch channels (col fastest, then row, then channel) and presents the
// sum on a valid/ready output.
//   clk, reset_n                      clock, async active-low reset
//   i_pe_en                           enable (weight writes, ifmap accepts)
//   i_filter_width, i_stride, i_num_ch window config, latched on IDLE->RUN
//   i_reset_ifmap                     synchronous window flush
//   i_en_loadi_left/upper             neighbour load enables in
//   o_en_loadi_right/lower            neighbour load enables out
//   o_cfg_err                         illegal config requested while IDLE
//   o_busy                            FSM not IDLE
//   bus                               ifmap/weight/result bundle (slave)
module pe_mc
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH        = ACC_WIDTH_DEF,
    parameter int MAX_FILTER_WIDTH = MAX_FILTER_WIDTH_DEF,
    parameter int MAX_CH           = MAX_CH_DEF,
    parameter bit SATURATE         = 1'b1,
    localparam int LOG_MFW         = $clog2(MAX_FILTER_WIDTH),
    localparam int LOG_CH          = $clog2(MAX_CH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_pe_en,
    input  logic [LOG_MFW:0] i_filter_width,
    input  logic [LOG_MFW:0] i_stride,
    input  logic [LOG_CH:0]  i_num_ch,
    input  logic             i_reset_ifmap,
    input  logic             i_en_loadi_left,
    input  logic             i_en_loadi_upper,
    output logic             o_en_loadi_right,
    output logic             o_en_loadi_lower,
    output logic             o_cfg_err,
    output logic             o_busy,
    pe_mc_if.slave           bus
);

    localparam logic [LOG_MFW:0] FW_ONE = (LOG_MFW+1)'(1);
    localparam logic [LOG_CH:0]  CH_ONE = (LOG_CH+1)'(1);
    localparam logic [LOG_MFW:0] FW_LIM = (LOG_MFW+1)'(MAX_FILTER_WIDTH);
    localparam logic [LOG_CH:0]  CH_LIM = (LOG_CH+1)'(MAX_CH);

    pe_state_e                   state;
    logic [LOG_MFW:0]            fw_q, stride_q;
    logic [LOG_CH:0]             nch_q;
    logic [LOG_MFW:0]            row, col;
    logic [LOG_CH:0]             ch;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        sat_q, valid_q, row_en;

    logic signed [DATA_WIDTH-1:0] wmem [MAX_CH][MAX_FILTER_WIDTH][MAX_FILTER_WIDTH];
    logic signed [DATA_WIDTH-1:0] w_cur;
    logic signed [ACC_WIDTH-1:0]  mac_acc;
    logic                         mac_sat;

    logic cfg_ok, w_we, accept, col_last, row_last, ch_last;

    assign cfg_ok = cfg_legal(32'(i_filter_width), 32'(i_stride), 32'(i_num_ch),
                              MAX_FILTER_WIDTH, MAX_CH);

    // ---------------- weight store ----------------
    // Out-of-range pointers are dropped rather than aliased onto a legal slot.
    assign w_we = bus.i_weight_valid & i_pe_en &
                  (bus.i_wr_w_ch_ptr  < CH_LIM) &
                  (bus.i_wr_w_row_ptr < FW_LIM) &
                  (bus.i_wr_w_col_ptr < FW_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < MAX_CH; c++)
                for (int r = 0; r < MAX_FILTER_WIDTH; r++)
                    for (int k = 0; k < MAX_FILTER_WIDTH; k++)
                        wmem[c][r][k] <= '0;
        end else if (w_we) begin
            wmem[bus.i_wr_w_ch_ptr[LOG_CH-1:0]]
                [bus.i_wr_w_row_ptr[LOG_MFW-1:0]]
                [bus.i_wr_w_col_ptr[LOG_MFW-1:0]] <= bus.i_weight_data;
        end
    end

    // Pointers never exceed the latched config, which is within the store.
    assign w_cur = wmem[ch[LOG_CH-1:0]][row[LOG_MFW-1:0]][col[LOG_MFW-1:0]];

    pe_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SATURATE   (SATURATE)
    ) u_mac (
        .acc      (acc),
        .weight   (w_cur),
        .ifmap    (bus.i_ifmap_data),
        .acc_next (mac_acc),
        .sat      (mac_sat)
    );

    // ---------------- control ----------------
    assign accept   = (state == ST_RUN) & i_pe_en & bus.i_ifmap_valid &
                      row_en & i_en_loadi_upper & ~i_reset_ifmap;
    assign col_last = (col == fw_q - FW_ONE);
    assign row_last = (row == fw_q - FW_ONE);
    assign ch_last  = (ch  == nch_q - CH_ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            fw_q     <= '0;
            stride_q <= '0;
            nch_q    <= '0;
            row      <= '0;
            col      <= '0;
            ch       <= '0;
            acc      <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
            row_en   <= 1'b0;
        end else if (i_reset_ifmap) begin
            // Flush wins over everything else this cycle; weights and the
            // latched config are left alone.
            state   <= ST_IDLE;
            row     <= '0;
            col     <= '0;
            ch      <= '0;
            acc     <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            row_en  <= 1'b0;
        end else begin
            // Left neighbour re-arms the row; finishing a row disarms it.
            if (i_en_loadi_left)
                row_en <= 1'b1;
            else if (accept && col_last)
                row_en <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_pe_en && cfg_ok) begin
                        state    <= ST_RUN;
                        fw_q     <= i_filter_width;
                        stride_q <= i_stride;
                        nch_q    <= i_num_ch;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        acc   <= mac_acc;
                        sat_q <= sat_q | mac_sat;
                        if (!col_last) begin
                            col <= col + FW_ONE;
                        end else begin
                            col <= '0;
                            if (!row_last) begin
                                row <= row + FW_ONE;
                            end else begin
                                row <= '0;
                                if (!ch_last) begin
                                    ch <= ch + CH_ONE;
                                end else begin
                                    ch      <= '0;
                                    state   <= ST_HOLD;
                                    valid_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.i_peout_ready) begin
                        valid_q <= 1'b0;
                        acc     <= '0;
                        sat_q   <= 1'b0;
                        state   <= i_pe_en ? ST_RUN : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.o_peout_data  = acc;
    assign bus.o_peout_valid = valid_q;
    assign bus.o_peout_sat   = sat_q;

    assign o_busy           = (state != ST_IDLE);
    assign o_cfg_err        = (state == ST_IDLE) & i_pe_en & ~cfg_ok;
    assign o_en_loadi_right = (state == ST_RUN) & (col == stride_q - FW_ONE);
    assign o_en_loadi_lower = ((state == ST_RUN) & (row >= stride_q)) |
                              (state == ST_HOLD);

endmodule

// File: tb/tb_pe_mc.sv
module tb_pe_mc;
    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int MFW = 11;
    localparam int MCH = 4;
    localparam int LM  = $clog2(MFW);
    localparam int LC  = $clog2(MCH);
    localparam longint AMAX = 64'sd2147483647;
    localparam longint AMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_pe_en = 1'b0;
    logic [LM:0]   i_filter_width = '0;
    logic [LM:0]   i_stride = '0;
    logic [LC:0]   i_num_ch = '0;
    logic          i_reset_ifmap = 1'b0;
    logic          i_en_loadi_left = 1'b0;
    logic          i_en_loadi_upper = 1'b0;
    logic          o_en_loadi_right, o_en_loadi_lower, o_cfg_err, o_busy;

    pe_mc_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_FILTER_WIDTH(MFW), .MAX_CH(MCH)) bus();

    pe_mc #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_FILTER_WIDTH(MFW), .MAX_CH(MCH), .SATURATE(1'b1)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_pe_en          (i_pe_en),
        .i_filter_width   (i_filter_width),
        .i_stride         (i_stride),
        .i_num_ch         (i_num_ch),
        .i_reset_ifmap    (i_reset_ifmap),
        .i_en_loadi_left  (i_en_loadi_left),
        .i_en_loadi_upper (i_en_loadi_upper),
        .o_en_loadi_right (o_en_loadi_right),
        .o_en_loadi_lower (o_en_loadi_lower),
        .o_cfg_err        (o_cfg_err),
        .o_busy           (o_busy),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int wm [MCH][MFW][MFW];   // reference copy of the weight store

    typedef struct { int fw; int st; int nch; bit err; } cfg_vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Window result straight from the arithmetic definition: walk the
    // samples in (ch,row,col) order, clamp after every step.
    function automatic longint model(input int fw, input int nch, input int xs[$], output bit sat);
        longint a = 0;
        int idx = 0;
        sat = 1'b0;
        for (int c = 0; c < nch; c++)
            for (int r = 0; r < fw; r++)
                for (int k = 0; k < fw; k++) begin
                    a += longint'(wm[c][r][k]) * longint'(xs[idx]);
                    idx++;
                    if (a > AMAX) begin a = AMAX; sat = 1'b1; end
                    if (a < AMIN) begin a = AMIN; sat = 1'b1; end
                end
        return a;
    endfunction

    // Weight write while parked in IDLE (num_ch=0 keeps the FSM from starting).
    task automatic wr_w(input int c, input int r, input int k, input int v);
        i_pe_en = 1'b1;
        i_num_ch = '0;
        bus.i_weight_valid = 1'b1;
        bus.i_wr_w_ch_ptr  = (LC+1)'(c);
        bus.i_wr_w_row_ptr = (LM+1)'(r);
        bus.i_wr_w_col_ptr = (LM+1)'(k);
        bus.i_weight_data  = DW'(v);
        if (c < MCH && r < MFW && k < MFW) wm[c][r][k] = v;
        @(posedge clk); #1;
        bus.i_weight_valid = 1'b0;
    endtask

    task automatic run_start(input int fw, input int st, input int nch, input string nm);
        i_filter_width = (LM+1)'(fw);
        i_stride = (LM+1)'(st);
        i_num_ch = (LC+1)'(nch);
        i_pe_en = 1'b1;
        i_en_loadi_left = 1'b1;
        i_en_loadi_upper = 1'b1;
        bus.i_ifmap_valid = 1'b0;
        bus.i_peout_ready = 1'b0;
        @(posedge clk); #1;
        chk({nm, " busy"}, o_busy, 1);
    endtask

    // Feed a full window with random valid/enable gaps; checks neighbour
    // enables against the sample position, then the result.
    task automatic feed(input int fw, input int st, input int xs[$],
                        input longint expd, input bit exps, input string nm);
        int n = 0;
        int cyc = 0;
        int bad_l = 0;
        int bad_v = 0;
        while (n < xs.size() && cyc < 4000) begin
            if (o_en_loadi_right !== ((n % fw) == st - 1)) bad_l++;
            if (o_en_loadi_lower !== (((n / fw) % fw) >= st)) bad_l++;
            if (bus.o_peout_valid !== 1'b0) bad_v++;
            i_pe_en = ($urandom_range(0, 4) != 0);
            bus.i_ifmap_valid = ($urandom_range(0, 3) != 0);
            bus.i_ifmap_data = DW'(xs[n]);
            @(posedge clk); #1;
            cyc++;
            if (i_pe_en && bus.i_ifmap_valid) n++;
        end
        i_pe_en = 1'b1;
        bus.i_ifmap_valid = 1'b0;
        chk({nm, " samples"}, n, xs.size());
        chk({nm, " loadi"}, bad_l, 0);
        chk({nm, " early_valid"}, bad_v, 0);
        chk({nm, " valid"}, bus.o_peout_valid, 1);
        chk({nm, " data"}, longint'(bus.o_peout_data), expd);
        chk({nm, " sat"}, bus.o_peout_sat, exps);
    endtask

    task automatic hs(input bit en_after, input string nm);
        bus.i_peout_ready = 1'b1;
        i_pe_en = en_after;
        @(posedge clk); #1;
        bus.i_peout_ready = 1'b0;
        chk({nm, " hs_valid"}, bus.o_peout_valid, 0);
        chk({nm, " hs_sat"}, bus.o_peout_sat, 0);
        chk({nm, " hs_busy"}, o_busy, en_after);
    endtask

    initial begin
        cfg_vec_t cv[$];
        int xs[$];
        int xs2[$];
        longint e;
        bit es;
        int fw, st, nch;

        bus.i_ifmap_data = '0;   bus.i_ifmap_valid = 1'b0;
        bus.i_weight_data = '0;  bus.i_weight_valid = 1'b0;
        bus.i_wr_w_ch_ptr = '0;  bus.i_wr_w_row_ptr = '0; bus.i_wr_w_col_ptr = '0;
        bus.i_peout_ready = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst data", longint'(bus.o_peout_data), 0);
        chk("rst valid", bus.o_peout_valid, 0);
        chk("rst sat", bus.o_peout_sat, 0);
        chk("rst busy", o_busy, 0);
        chk("rst right", o_en_loadi_right, 0);
        chk("rst lower", o_en_loadi_lower, 0);
        chk("rst cfg_err idle", o_cfg_err, 0);
        i_pe_en = 1'b1; i_filter_width = 3; i_stride = 1; i_num_ch = 0;
        #1;
        chk("rst cfg_err comb", o_cfg_err, 1);
        i_pe_en = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // ---- config legality table ----
        cv.push_back('{3, 1, 1, 1'b0});
        cv.push_back('{3, 1, 0, 1'b1});
        cv.push_back('{3, 4, 1, 1'b1});
        cv.push_back('{11, 11, 4, 1'b0});
        cv.push_back('{1, 1, 1, 1'b0});
        cv.push_back('{0, 0, 1, 1'b1});
        cv.push_back('{12, 1, 1, 1'b1});
        cv.push_back('{3, 3, 5, 1'b1});
        cv.push_back('{3, 0, 1, 1'b1});
        foreach (cv[i]) begin
            @(negedge clk);
            i_filter_width = (LM+1)'(cv[i].fw);
            i_stride = (LM+1)'(cv[i].st);
            i_num_ch = (LC+1)'(cv[i].nch);
            i_pe_en = 1'b1;
            #1;
            chk($sformatf("cfg_err[%0d]", i), o_cfg_err, cv[i].err);
            if (cv[i].err) begin
                @(posedge clk); #1;
                chk($sformatf("cfg_idle[%0d]", i), o_busy, 0);
            end
            i_pe_en = 1'b0;
        end
        @(posedge clk); #1;

        // ---- 3x3, weights 1, ifmap 1..9 -> 45; stray ch=4 write must drop ----
        for (int r = 0; r < 3; r++) for (int k = 0; k < 3; k++) wr_w(0, r, k, 1);
        wr_w(4, 0, 0, 1000);
        run_start(3, 1, 1, "sum45");
        xs.delete();
        for (int i = 1; i <= 9; i++) xs.push_back(i);
        feed(3, 1, xs, 45, 1'b0, "sum45");
        hs(1'b0, "sum45");

        // ---- 2x2, 2 channels: 4*8 - 4*12 = -16 ----
        for (int r = 0; r < 2; r++) for (int k = 0; k < 2; k++) begin
            wr_w(0, r, k, 2);
            wr_w(1, r, k, -3);
        end
        run_start(2, 1, 2, "twoch");
        xs.delete();
        for (int i = 0; i < 8; i++) xs.push_back(4);
        feed(2, 1, xs, -16, 1'b0, "twoch");
        hs(1'b0, "twoch");

        // ---- random windows against the model ----
        for (int t = 0; t < 6; t++) begin
            fw = $urandom_range(1, 5);
            st = $urandom_range(1, fw);
            nch = $urandom_range(1, 4);
            for (int c = 0; c < nch; c++)
                for (int r = 0; r < fw; r++)
                    for (int k = 0; k < fw; k++)
                        wr_w(c, r, k, int'($signed(16'($urandom))));
            xs.delete();
            for (int i = 0; i < nch * fw * fw; i++) xs.push_back(int'($signed(16'($urandom))));
            e = model(fw, nch, xs, es);
            run_start(fw, st, nch, $sformatf("rnd%0d", t));
            feed(fw, st, xs, e, es, $sformatf("rnd%0d", t));
            hs(1'b0, $sformatf("rnd%0d", t));
        end

        // ---- result held while not ready, then back-to-back window ----
        xs.delete();
        for (int i = 0; i < 4; i++) xs.push_back(int'($signed(16'($urandom))));
        e = model(2, 1, xs, es);
        run_start(2, 1, 1, "hold");
        feed(2, 1, xs, e, es, "hold");
        for (int i = 0; i < 5; i++) begin
            bus.i_ifmap_valid = 1'b1;
            bus.i_ifmap_data = 16'sd77;
            @(posedge clk); #1;
            chk($sformatf("hold valid%0d", i), bus.o_peout_valid, 1);
            chk($sformatf("hold data%0d", i), longint'(bus.o_peout_data), e);
        end
        bus.i_ifmap_valid = 1'b0;
        hs(1'b1, "hold");
        xs2.delete();
        for (int i = 0; i < 4; i++) xs2.push_back(int'($signed(16'($urandom))));
        e = model(2, 1, xs2, es);
        feed(2, 1, xs2, e, es, "hold2");
        hs(1'b0, "hold2");

        // ---- flush after 4 of 9 samples, then a clean rerun ----
        run_start(3, 1, 1, "flush");
        for (int i = 0; i < 4; i++) begin
            bus.i_ifmap_valid = 1'b1;
            bus.i_ifmap_data = 16'sd1000;
            @(posedge clk); #1;
        end
        i_reset_ifmap = 1'b1;
        @(posedge clk); #1;
        i_reset_ifmap = 1'b0;
        bus.i_ifmap_valid = 1'b0;
        chk("flush busy", o_busy, 0);
        chk("flush valid", bus.o_peout_valid, 0);
        chk("flush data", longint'(bus.o_peout_data), 0);
        xs.delete();
        for (int i = 0; i < 9; i++) xs.push_back(int'($signed(16'($urandom))));
        e = model(3, 1, xs, es);
        run_start(3, 1, 1, "rerun");
        feed(3, 1, xs, e, es, "rerun");
        hs(1'b0, "rerun");

        // ---- row enable gating: one row per left pulse, upper gates too ----
        xs.delete();
        for (int i = 0; i < 9; i++) xs.push_back(3);
        e = model(3, 1, xs, es);
        run_start(3, 1, 1, "rowen");
        i_en_loadi_left = 1'b0;
        bus.i_ifmap_data = 16'sd3;
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 0) begin
                i_en_loadi_upper = 1'b0;
                bus.i_ifmap_valid = 1'b1;
                repeat (2) begin @(posedge clk); #1; end
                i_en_loadi_upper = 1'b1;
            end else begin
                i_en_loadi_left = 1'b1;
                bus.i_ifmap_valid = 1'b0;
                @(posedge clk); #1;
                i_en_loadi_left = 1'b0;
                bus.i_ifmap_valid = 1'b1;
            end
            repeat (5) begin @(posedge clk); #1; end
            if (ph < 2) begin
                chk($sformatf("rowen valid%0d", ph), bus.o_peout_valid, 0);
                chk($sformatf("rowen lower%0d", ph), o_en_loadi_lower, 1);
                chk($sformatf("rowen right%0d", ph), o_en_loadi_right, 1);
            end
        end
        bus.i_ifmap_valid = 1'b0;
        chk("rowen valid", bus.o_peout_valid, 1);
        chk("rowen data", longint'(bus.o_peout_data), e);
        hs(1'b0, "rowen");

        // ---- saturation: 11x11x4 of 0x7FFF, positive then negative ----
        for (int c = 0; c < MCH; c++)
            for (int r = 0; r < MFW; r++)
                for (int k = 0; k < MFW; k++)
                    wr_w(c, r, k, 32767);
        xs.delete();
        for (int i = 0; i < MCH * MFW * MFW; i++) xs.push_back(32767);
        run_start(11, 1, 4, "satpos");
        feed(11, 1, xs, AMAX, 1'b1, "satpos");
        hs(1'b0, "satpos");
        xs.delete();
        for (int i = 0; i < MCH * MFW * MFW; i++) xs.push_back(-32768);
        run_start(11, 3, 4, "satneg");
        feed(11, 3, xs, AMIN, 1'b1, "satneg");
        hs(1'b0, "satneg");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pe_mc.md
PE_MC -- requirements
Module: pe_mc

Interface
REQ-001 Parameter DATA_WIDTH, 16, signed ifmap/weight operand width.
REQ-002 Parameter ACC_WIDTH, 32, signed accumulator/output width; SHALL be >= 2*DATA_WIDTH.
REQ-003 Parameter MAX_FILTER_WIDTH, 11, max filter row/col count; LOG_MFW = $clog2(MAX_FILTER_WIDTH).
REQ-004 Parameter MAX_CH, 4, max input channels accumulated per output; LOG_CH = $clog2(MAX_CH).
REQ-005 Parameter SATURATE, 1, 1 = clamp on accumulator overflow, 0 = wrap.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 i_pe_en  in  1  PE enable; gates weight writes and ifmap acceptance.
REQ-009 i_filter_width, i_stride  in  LOG_MFW+1 each  window size, stride.
REQ-010 i_num_ch  in  LOG_CH+1  channels per output.
REQ-011 i_ifmap_data  in  DATA_WIDTH;  i_ifmap_valid  in  1  ifmap sample qualifier.
REQ-012 i_reset_ifmap  in  1  synchronous window flush.
REQ-013 i_en_loadi_left, i_en_loadi_upper  in  1 each  neighbour load enables.
REQ-014 i_weight_data  in  DATA_WIDTH;  i_weight_valid  in  1;  i_wr_w_ch_ptr  in  LOG_CH+1;  i_wr_w_row_ptr, i_wr_w_col_ptr  in  LOG_MFW+1.
REQ-015 o_peout_data  out  ACC_WIDTH;  o_peout_valid  out  1;  i_peout_ready  in  1  output handshake.
REQ-016 o_peout_sat  out  1  result clamped; o_cfg_err  out  1  illegal config; o_busy  out  1  state != IDLE.
REQ-017 o_en_loadi_right, o_en_loadi_lower  out  1 each  neighbour load enables.

Function
REQ-018 Weight store MAX_CH x MAX_FILTER_WIDTH x MAX_FILTER_WIDTH; write when i_weight_valid & i_pe_en & all ptrs in range; out-of-range writes dropped; writes legal in any state, visible next cycle.
REQ-019 FSM states IDLE, RUN, HOLD.
REQ-020 IDLE->RUN when i_pe_en=1 and config legal (1<=filter_width<=MFW, 1<=stride<=filter_width, 1<=num_ch<=MAX_CH); config latched on this transition, ignored until next IDLE.
REQ-021 Illegal config with i_pe_en=1 in IDLE: stay IDLE, o_cfg_err=1 (combinational on current inputs).
REQ-022 RUN accept = i_pe_en & i_ifmap_valid & row_en & i_en_loadi_upper.
REQ-023 Read order: col fastest, then row, then channel; each accept advances col, wraps col at fw-1 incrementing row, wraps row at fw-1 incrementing ch.
REQ-024 Accept: acc <= acc + signed(weight[ch][row][col] * i_ifmap_data), same cycle, no pipeline.
REQ-025 SATURATE=1: overflow clamps to ACC max/min, sets sticky sat flag for this window; SATURATE=0: two's-complement wrap, flag stays 0.
REQ-026 Accept at (num_ch-1, fw-1, fw-1): ptrs->0, RUN->HOLD; o_peout_valid=1 next cycle (latency 1 from last sample).
REQ-027 HOLD: o_peout_data, o_peout_sat stable, o_peout_valid held until i_peout_ready=1; no accepts.
REQ-028 HOLD with i_peout_ready=1: valid, acc, sat flag clear next cycle; ->RUN if i_pe_en else IDLE.
REQ-029 row_en: set on i_en_loadi_left; else cleared on accept at col fw-1; set wins over clear.
REQ-030 o_en_loadi_right = RUN & (col == stride-1).
REQ-031 o_en_loadi_lower = (RUN & row >= stride) | HOLD.
REQ-032 i_pe_en=0 in RUN freezes ptrs/acc (no accept); no state change.
REQ-033 i_reset_ifmap=1: ptrs, acc, sat flag, valid, row_en clear; FSM->IDLE next cycle; weights kept; overrides all same-cycle events.

Reset
REQ-034 reset_n=0 asynchronously: FSM IDLE, ptrs 0, acc 0, weights 0, row_en 0, latched config 0.
REQ-035 Outputs in reset: o_peout_data 0, o_peout_valid 0, o_peout_sat 0, o_busy 0, o_en_loadi_* 0; o_cfg_err combinational.

Structure
REQ-036 Shared package pe_pkg: FSM state enum, DATA_WIDTH/ACC_WIDTH/MAX_FILTER_WIDTH/MAX_CH defaults, config-legality function.
REQ-037 One sub-module pe_mac: signed multiply, ACC_WIDTH add, saturation detect/clamp, combinational.

Verification
REQ-038 fw=3, stride=1, num_ch=1, weights all 1, ifmap 1..9 -> o_peout_data=45, valid 1 cycle after 9th accept.
REQ-039 fw=2, num_ch=2, ch0 w=2, ch1 w=-3, ifmap all 4 -> 8 accepts, output 4*8 - 4*12 = -16.
REQ-040 ACC_WIDTH=32, SATURATE=1, weights 0x7FFF, ifmap 0x7FFF, fw=11, num_ch=4 -> o_peout_data=0x7FFFFFFF, o_peout_sat=1.
REQ-041 Result ready, i_peout_ready low 5 cycles -> valid/data stable 5 cycles; ready high -> cleared next cycle, next window accumulates from 0.
REQ-042 i_reset_ifmap after 4 of 9 accepts -> IDLE, acc 0, weights intact; rerun gives correct full result.
REQ-043 num_ch=0 or stride=4 with fw=3, i_pe_en=1 -> o_cfg_err=1, stays IDLE, o_busy=0.
